// File: rtl/buzzer_note_sequencer.sv
// Note-table melody player: walks a writable table of {half_period, dur_ticks}
// entries and drives a square wave on buzz_out, with optional looping.
module buzzer_note_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int NOTE_DEPTH = 16,
  parameter int AW         = 4,
  parameter int DIV_W      = 20,
  parameter int DUR_W      = 12
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop_en,
  input  logic [AW:0]            num_notes,
  input  logic                   tbl_we,
  input  logic [AW-1:0]          tbl_addr,
  input  logic [DIV_W+DUR_W-1:0] tbl_wdata,
  output logic                   buzz_out,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          cur_idx
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [AW:0]              count_q, count_d;
  logic [DIV_W-1:0]         half_q, half_d;
  logic [DIV_W-1:0]         tone_q, tone_d;
  logic [DUR_W-1:0]         ticks_q, ticks_d;
  logic [PW-1:0]            pre_q, pre_d;
  logic                     buzz_q, buzz_d;
  logic                     done_q, done_d;
  logic                     advance;

  logic [DIV_W+DUR_W-1:0]   tbl [NOTE_DEPTH];
  logic [DIV_W-1:0]         entry_half;
  logic [DUR_W-1:0]         entry_dur;
  logic [AW:0]              num_sat;
  logic                     last_note;

  assign {entry_half, entry_dur} = tbl[idx_q];
  assign num_sat   = (num_notes > (AW+1)'(NOTE_DEPTH)) ? (AW+1)'(NOTE_DEPTH) : num_notes;
  assign last_note = ({1'b0, idx_q} + (AW+1)'(1)) >= count_q;

  // NOTE: the note table is plain storage with no reset, so it stays a RAM-friendly array.
  always_ff @(posedge ACLK) begin
    if (tbl_we) tbl[tbl_addr] <= tbl_wdata;
  end

  // NOTE: every next-state variable takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    half_d  = half_q;
    tone_d  = tone_q;
    ticks_d = ticks_q;
    pre_d   = pre_q;
    buzz_d  = buzz_q;
    done_d  = 1'b0;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          count_d = num_sat;
          if (num_sat == '0) done_d  = 1'b1;
          else               state_d = LOAD;
        end
      end
      LOAD: begin
        half_d  = entry_half;
        ticks_d = entry_dur;
        pre_d   = '0;
        tone_d  = '0;
        buzz_d  = 1'b0;
        if (entry_dur == '0) advance = 1'b1;
        else                 state_d = PLAY;
      end
      PLAY: begin
        if (half_q == '0) begin
          buzz_d = 1'b0;
        end else if (tone_q == half_q - DIV_W'(1)) begin
          tone_d = '0;
          buzz_d = ~buzz_q;
        end else begin
          tone_d = tone_q + DIV_W'(1);
        end
        if (pre_q == PW'(TICK_DIV - 1)) begin
          pre_d   = '0;
          ticks_d = ticks_q - DUR_W'(1);
          if (ticks_q == DUR_W'(1)) begin
            advance = 1'b1;
            buzz_d  = 1'b0;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Shared next-note step for both a skipped entry and a finished note.
    if (advance) begin
      if (!last_note) begin
        idx_d   = idx_q + AW'(1);
        state_d = LOAD;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = LOAD;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    if (stop) begin
      state_d = IDLE;
      buzz_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      count_q <= '0;
      half_q  <= '0;
      tone_q  <= '0;
      ticks_q <= '0;
      pre_q   <= '0;
      buzz_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      half_q  <= half_d;
      tone_q  <= tone_d;
      ticks_q <= ticks_d;
      pre_q   <= pre_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
    end
  end

  assign buzz_out = buzz_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cur_idx  = idx_q;

endmodule

// File: tb/tb_buzzer_note_sequencer.sv
// Bench for buzzer_note_sequencer: directed scenarios plus random melodies, each
// compared cycle by cycle against a timeline computed from the note table.
module tb_buzzer_note_sequencer;

  localparam int TICK = 10;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [4:0]  num_notes = '0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = '0;
  logic [31:0] tbl_wdata = '0;
  logic        buzz_out, busy, done;
  logic [3:0]  cur_idx;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       buzz;
    logic [3:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   hp_m [16];
  int   dur_m[16];

  buzzer_note_sequencer #(
    .TICK_DIV(TICK), .NOTE_DEPTH(16), .AW(4), .DIV_W(20), .DUR_W(12)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .stop(stop), .loop_en(loop_en),
    .num_notes(num_notes), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .buzz_out(buzz_out), .busy(busy), .done(done), .cur_idx(cur_idx)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int a, input int hp, input int dur);
    tbl_we    = 1'b1;
    tbl_addr  = 4'(a);
    tbl_wdata = {20'(hp), 12'(dur)};
    tick();
    tbl_we    = 1'b0;
    hp_m[a]   = hp;
    dur_m[a]  = dur;
  endtask

  // Expected output timeline, one entry per cycle starting just after the start edge:
  // each note is one load cycle then dur*TICK play cycles with buzz = (k / hp) mod 2.
  task automatic build(input int n, input int reps, output int pass_len);
    int nn;
    exp_q.delete();
    pass_len = 0;
    nn = (n > 16) ? 16 : n;
    if (nn == 0) begin
      exp_q.push_back('{1'b0, 1'b1, 1'b0, 4'd0});
      exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'd0});
      return;
    end
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nn; i++) begin
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'(i)});
        for (int k = 0; k < dur_m[i] * TICK; k++)
          exp_q.push_back('{1'b1, 1'b0,
                            (hp_m[i] == 0) ? 1'b0 : 1'((k / hp_m[i]) % 2), 4'(i)});
      end
      if (r == 0) pass_len = exp_q.size();
    end
    exp_q.push_back('{1'b0, 1'b1, 1'b0, 4'(nn - 1)});
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'(nn - 1)});
  endtask

  // Start a melody and compare every cycle; optional extra start pulse and table write mid-run.
  task automatic play(input string name, input int n, input int reps, input int extra_start_at,
                      input int wr_at, input int wr_addr, input int wr_hp, input int wr_dur);
    int pass_len;
    if (wr_at >= 0) begin
      hp_m[wr_addr]  = wr_hp;
      dur_m[wr_addr] = wr_dur;
    end
    build(n, reps, pass_len);
    num_notes = 5'(n);
    loop_en   = (reps > 1);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      if (reps > 1 && j == (reps - 1) * pass_len) loop_en = 1'b0;
      start     = (j == extra_start_at);
      tbl_we    = (j == wr_at);
      tbl_addr  = 4'(wr_addr);
      tbl_wdata = {20'(wr_hp), 12'(wr_dur)};
      check({name, " busy"},    32'(busy),     32'(exp_q[j].busy));
      check({name, " done"},    32'(done),     32'(exp_q[j].done));
      check({name, " buzz"},    32'(buzz_out), 32'(exp_q[j].buzz));
      check({name, " cur_idx"}, 32'(cur_idx),  32'(exp_q[j].idx));
      tick();
    end
    start  = 1'b0;
    tbl_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      hp_m[i]  = 0;
      dur_m[i] = 0;
    end
    tick();
    check("reset busy",    32'(busy),     32'd0);
    check("reset done",    32'(done),     32'd0);
    check("reset buzz",    32'(buzz_out), 32'd0);
    check("reset cur_idx", 32'(cur_idx),  32'd0);
    ARESETN = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) write_entry(i, 1, 1);

    // Single note {4,3}
    write_entry(0, 4, 3);
    play("single", 1, 1, -1, -1, 0, 0, 0);

    // Rest, skipped entry, short tone
    write_entry(0, 0, 2);
    write_entry(1, 5, 0);
    write_entry(2, 3, 1);
    play("rest_skip", 3, 1, -1, -1, 0, 0, 0);

    // Loop twice more, then loop_en cleared during the third pass
    write_entry(0, 2, 1);
    write_entry(1, 3, 1);
    play("loop", 2, 3, -1, -1, 0, 0, 0);

    // Stop mid note 1
    write_entry(0, 3, 2);
    write_entry(1, 2, 3);
    num_notes = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    check("stop pre busy", 32'(busy),    32'd1);
    check("stop pre idx",  32'(cur_idx), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop busy", 32'(busy),     32'd0);
    check("stop buzz", 32'(buzz_out), 32'd0);
    check("stop done", 32'(done),     32'd0);
    tick();
    check("stop done later", 32'(done), 32'd0);
    check("stop idle",       32'(busy), 32'd0);

    // Stop and start together from IDLE
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    check("stop+start busy", 32'(busy), 32'd0);
    check("stop+start done", 32'(done), 32'd0);
    tick();
    check("stop+start busy later", 32'(busy), 32'd0);

    // Empty melody, start while busy, rewrite of a later entry during playback
    play("zero_notes", 0, 1, -1, -1, 0, 0, 0);
    write_entry(0, 3, 2);
    write_entry(1, 2, 1);
    play("start_busy", 2, 1, 3, -1, 0, 0, 0);
    play("rewrite", 2, 1, -1, 4, 1, 5, 2);
    play("saturate", 25, 1, -1, -1, 0, 0, 0);

    // Asynchronous reset mid-play
    write_entry(0, 2, 1);
    write_entry(1, 2, 3);
    num_notes = 5'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("pre-reset buzz", 32'(buzz_out), 32'd1);
    check("pre-reset idx",  32'(cur_idx),  32'd1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("async reset busy",    32'(busy),     32'd0);
    check("async reset buzz",    32'(buzz_out), 32'd0);
    check("async reset done",    32'(done),     32'd0);
    check("async reset cur_idx", 32'(cur_idx),  32'd0);
    tick();
    tick();
    ARESETN = 1'b1;
    tick();
    play("after_reset", 2, 1, -1, -1, 0, 0, 0);

    // Random melodies
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++)
        write_entry(i, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      play("random", int'($urandom_range(0, 20)), 1, -1, -1, 0, 0, 0);
    end
    write_entry(0, int'($urandom_range(1, 5)), int'($urandom_range(1, 2)));
    write_entry(1, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    write_entry(2, int'($urandom_range(1, 5)), int'($urandom_range(1, 2)));
    play("random_loop", 3, 2, -1, -1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
